uart_rx_cfg: RTL

Parametrised, runtime-configurable UART receiver; the next generation of `uart_rx`. Oversamples `rx` on the shared baud tick (`b_tick`), deserialises 5–8 data bits LSB-first, and checks optional odd/even parity and 1 or 2 stop bits. Reports parity, framing, break and overrun errors. Presents each byte on a valid/ready handshake toward the RX FIFO, which feeds the AXI-Lite register block.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_sampler.sv | 67 ++++++
 rtl/uart_rx_cfg.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// data-length encoding, receiver states and small decode helpers.
package uart_pkg;

    // Parity mode encoding on the parity input; 2'b11 also means no parity.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Data length encoding on the data_bits input.
    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rxState_e;

    // Index of the last data bit for a given length code (5 bits -> 4 ... 8 bits -> 7).
    function automatic logic [2:0] lastBitIndex(input logic [1:0] dataBits);
        return {1'b0, dataBits} + 3'd4;
    endfunction

    function automatic logic parityEnabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser and bit sampler for uart_rx_cfg.
// Build option UART_RX_MAJORITY_VOTE_EN: when defined, each bit is the 2-of-3
// majority of rxs at ticks OSR/2-2, OSR/2-1 and OSR/2; otherwise it is the single
// sample taken at tick OSR/2-1. The sample strobe fires at tick OSR/2 in both
// builds so frame timing does not depend on the option.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TCNT_W      = 4
) (
    input  logic              clk,
    input  logic              a_resetn,
    input  logic              tick_i,
    input  logic [TCNT_W-1:0] tcnt_i,
    input  logic              rx_i,
    output logic              rxs_o,
    output logic              sample_o,
    output logic              sample_strobe_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   midSample_q;

    // Synchroniser chain; flops reset to the idle line level.
    always_ff @(posedge clk) begin
        if (!a_resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs_o = sync_q[SYNC_STAGES-1];

    // Capture the centre sample of the current bit.
    always_ff @(posedge clk) begin
        if (!a_resetn) begin
            midSample_q <= 1'b1;
        end else if (tick_i && (tcnt_i == TCNT_W'(OSR/2 - 1))) begin
            midSample_q <= rxs_o;
        end
    end

    assign sample_strobe_o = tick_i && (tcnt_i == TCNT_W'(OSR/2));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic earlySample_q;

    // Capture the sample one tick ahead of centre for the vote.
    always_ff @(posedge clk) begin
        if (!a_resetn) begin
            earlySample_q <= 1'b1;
        end else if (tick_i && (tcnt_i == TCNT_W'(OSR/2 - 2))) begin
            earlySample_q <= rxs_o;
        end
    end

    assign sample_o = (earlySample_q & midSample_q) |
                      (earlySample_q & rxs_o) |
                      (midSample_q & rxs_o);
`else
    assign sample_o = midSample_q;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, none/odd/even parity,
// 1 or 2 stop bits) with parity, framing, break and overrun reporting and a
// valid/ready output. Build option UART_RX_MAJORITY_VOTE_EN selects 2-of-3
// majority sampling inside uart_rx_sampler.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       a_resetn,
    input  logic       b_tick,
    input  logic       rx,
    input  logic [1:0] parity,
    input  logic [1:0] data_bits,
    input  logic       stop_bits,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun
);

    localparam int                 TCNT_W   = $clog2(OSR);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(OSR - 1);

    rxState_e          state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        cfgParity_q, cfgParity_d;
    logic [1:0]        cfgBits_q, cfgBits_d;
    logic              cfgStop_q, cfgStop_d;
    logic              parErr_q, parErr_d;
    logic              parBit_q, parBit_d;
    logic              frameErr_q, frameErr_d;
    logic              complete;
    logic              breakHit;
    logic              xorAll;

    logic [7:0]        dout_q;
    logic              doutValid_q, rxDone_q, outParErr_q, outFrameErr_q, outBreak_q, overrun_q;

    logic              rxs, bitVal, sampleStrobe;

    uart_rx_sampler #(
        .OSR         (OSR),
        .SYNC_STAGES (SYNC_STAGES),
        .TCNT_W      (TCNT_W)
    ) u_sampler (
        .clk             (clk),
        .a_resetn        (a_resetn),
        .tick_i          (b_tick),
        .tcnt_i          (tcnt_q),
        .rx_i            (rx),
        .rxs_o           (rxs),
        .sample_o        (bitVal),
        .sample_strobe_o (sampleStrobe)
    );

    // Frame state, counters, shift data and latched configuration.
    always_ff @(posedge clk) begin
        if (!a_resetn) begin
            state_q     <= RX_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            data_q      <= '0;
            cfgParity_q <= PAR_NONE;
            cfgBits_q   <= DBITS_8;
            cfgStop_q   <= 1'b0;
            parErr_q    <= 1'b0;
            parBit_q    <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            data_q      <= data_d;
            cfgParity_q <= cfgParity_d;
            cfgBits_q   <= cfgBits_d;
            cfgStop_q   <= cfgStop_d;
            parErr_q    <= parErr_d;
            parBit_q    <= parBit_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Next-state logic; the tick counter stays bit-aligned from the start edge.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        data_d      = data_q;
        cfgParity_d = cfgParity_q;
        cfgBits_d   = cfgBits_q;
        cfgStop_d   = cfgStop_q;
        parErr_d    = parErr_q;
        parBit_d    = parBit_q;
        frameErr_d  = frameErr_q;
        complete    = 1'b0;
        breakHit    = 1'b0;
        xorAll      = (^data_q) ^ bitVal;

        if (b_tick) begin
            tcnt_d = (tcnt_q == TCNT_MAX) ? '0 : tcnt_q + TCNT_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    tcnt_d  = '0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (sampleStrobe) begin
                    if (!bitVal) begin
                        bcnt_d      = '0;
                        data_d      = '0;
                        parErr_d    = 1'b0;
                        parBit_d    = 1'b0;
                        frameErr_d  = 1'b0;
                        cfgParity_d = parity;
                        cfgBits_d   = data_bits;
                        cfgStop_d   = stop_bits;
                        state_d     = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (sampleStrobe) begin
                    data_d[bcnt_q] = bitVal;
                    if (bcnt_q == lastBitIndex(cfgBits_q)) begin
                        bcnt_d  = '0;
                        state_d = parityEnabled(cfgParity_q) ? RX_PARITY : RX_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (sampleStrobe) begin
                    parBit_d = bitVal;
                    parErr_d = (cfgParity_q == PAR_ODD) ? ~xorAll : xorAll;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sampleStrobe) begin
                    frameErr_d = frameErr_q | ~bitVal;
                    if (bcnt_q == {2'b00, cfgStop_q}) begin
                        complete = 1'b1;
                        breakHit = (data_q == 8'h00) &&
                                   (!parityEnabled(cfgParity_q) || !parBit_q) &&
                                   frameErr_d;
                        bcnt_d   = '0;
                        state_d  = breakHit ? RX_BREAK : RX_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
            RX_BREAK: begin
                if (b_tick && rxs) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Output registers: load on frame completion, handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (!a_resetn) begin
            dout_q        <= '0;
            doutValid_q   <= 1'b0;
            rxDone_q      <= 1'b0;
            outParErr_q   <= 1'b0;
            outFrameErr_q <= 1'b0;
            outBreak_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rxDone_q <= complete;
            if (complete) begin
                dout_q        <= data_q;
                outParErr_q   <= parErr_q;
                outFrameErr_q <= frameErr_d;
                outBreak_q    <= breakHit;
                doutValid_q   <= 1'b1;
                if (doutValid_q && !dout_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (doutValid_q && dout_ready) begin
                doutValid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign rx_done    = rxDone_q;
    assign parity_err = outParErr_q;
    assign frame_err  = outFrameErr_q;
    assign break_det  = outBreak_q;
    assign overrun    = overrun_q;

endmodule
